// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: holds ALU/branch ops until both operands are
// available, snoops ALU/LSB result broadcasts, and issues one ready op per cycle.
module rs_issue_sched #(
  parameter int DEPTH    = 16,
  parameter int OPNUM_W  = 6,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                alloc_valid,
  input  logic [OPNUM_W-1:0]  alloc_opnum,
  input  logic [DATA_W-1:0]   alloc_V1,
  input  logic [DATA_W-1:0]   alloc_V2,
  input  logic                alloc_Q1_busy,
  input  logic                alloc_Q2_busy,
  input  logic [ROB_ID_W-1:0] alloc_Q1,
  input  logic [ROB_ID_W-1:0] alloc_Q2,
  input  logic [DATA_W-1:0]   alloc_imm,
  input  logic [DATA_W-1:0]   alloc_pc,
  input  logic [ROB_ID_W-1:0] alloc_rob_id,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [DATA_W-1:0]   lsb_data,
  output logic [OPNUM_W-1:0]  opnum_to_ex,
  output logic [DATA_W-1:0]   V1_to_ex,
  output logic [DATA_W-1:0]   V2_to_ex,
  output logic [DATA_W-1:0]   imm_to_ex,
  output logic [DATA_W-1:0]   pc_to_ex,
  output logic [ROB_ID_W-1:0] rob_id_to_ex,
  output logic                rs_full
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_MARK = CNT_W'(DEPTH - 1);

  logic [DEPTH-1:0]    busy_reg, q1_busy_reg, q2_busy_reg;
  logic [OPNUM_W-1:0]  opnum_reg  [DEPTH];
  logic [DATA_W-1:0]   v1_reg     [DEPTH];
  logic [DATA_W-1:0]   v2_reg     [DEPTH];
  logic [DATA_W-1:0]   imm_reg    [DEPTH];
  logic [DATA_W-1:0]   pc_reg     [DEPTH];
  logic [ROB_ID_W-1:0] q1_reg     [DEPTH];
  logic [ROB_ID_W-1:0] q2_reg     [DEPTH];
  logic [ROB_ID_W-1:0] rob_id_reg [DEPTH];
  logic [CNT_W-1:0]    count_reg, count_next;

  logic [DEPTH-1:0]    q1_busy_next, q2_busy_next, candidate;
  logic [DATA_W-1:0]   v1_next [DEPTH];
  logic [DATA_W-1:0]   v2_next [DEPTH];

  // Per-entry wakeup; the ALU broadcast takes precedence over the LSB on a tag clash.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
    logic q1_alu, q1_lsb, q2_alu, q2_lsb;
    assign q1_alu = q1_busy_reg[gi] && alu_valid && (q1_reg[gi] == alu_rob_id);
    assign q1_lsb = q1_busy_reg[gi] && lsb_valid && (q1_reg[gi] == lsb_rob_id);
    assign q2_alu = q2_busy_reg[gi] && alu_valid && (q2_reg[gi] == alu_rob_id);
    assign q2_lsb = q2_busy_reg[gi] && lsb_valid && (q2_reg[gi] == lsb_rob_id);
    assign v1_next[gi]      = q1_alu ? alu_data : (q1_lsb ? lsb_data : v1_reg[gi]);
    assign v2_next[gi]      = q2_alu ? alu_data : (q2_lsb ? lsb_data : v2_reg[gi]);
    assign q1_busy_next[gi] = q1_busy_reg[gi] && !q1_alu && !q1_lsb;
    assign q2_busy_next[gi] = q2_busy_reg[gi] && !q2_alu && !q2_lsb;
    assign candidate[gi]    = busy_reg[gi] && !q1_busy_reg[gi] && !q2_busy_reg[gi];
  end

  // Same-cycle bypass for an operand whose producer broadcasts while it dispatches.
  logic                a1_alu, a1_lsb, a2_alu, a2_lsb;
  logic                alloc_q1_busy, alloc_q2_busy;
  logic [DATA_W-1:0]   alloc_v1, alloc_v2;
  assign a1_alu = alloc_Q1_busy && alu_valid && (alloc_Q1 == alu_rob_id);
  assign a1_lsb = alloc_Q1_busy && lsb_valid && (alloc_Q1 == lsb_rob_id);
  assign a2_alu = alloc_Q2_busy && alu_valid && (alloc_Q2 == alu_rob_id);
  assign a2_lsb = alloc_Q2_busy && lsb_valid && (alloc_Q2 == lsb_rob_id);
  assign alloc_v1      = a1_alu ? alu_data : (a1_lsb ? lsb_data : alloc_V1);
  assign alloc_v2      = a2_alu ? alu_data : (a2_lsb ? lsb_data : alloc_V2);
  assign alloc_q1_busy = alloc_Q1_busy && !a1_alu && !a1_lsb;
  assign alloc_q2_busy = alloc_Q2_busy && !a2_alu && !a2_lsb;

  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             has_free, has_sel, alloc_fire, issue_fire;

  // Downward scan so the lowest index is the last (winning) assignment.
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    has_free = 1'b0;
    has_sel  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_reg[i]) begin
        free_idx = IDX_W'(i);
        has_free = 1'b1;
      end
      if (candidate[i]) begin
        sel_idx = IDX_W'(i);
        has_sel = 1'b1;
      end
    end
  end

  assign alloc_fire = alloc_valid && has_free;
  assign issue_fire = has_sel;
  assign count_next = count_reg + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
  assign rs_full    = (count_reg >= FULL_MARK);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg     <= '0;
      q1_busy_reg  <= '0;
      q2_busy_reg  <= '0;
      count_reg    <= '0;
      opnum_to_ex  <= '0;
      V1_to_ex     <= '0;
      V2_to_ex     <= '0;
      imm_to_ex    <= '0;
      pc_to_ex     <= '0;
      rob_id_to_ex <= '0;
    end else if (rollback) begin
      busy_reg    <= '0;
      count_reg   <= '0;
      opnum_to_ex <= '0;
    end else if (!rdy) begin
      // Frozen: drop the issue slot so execute does not replay the last op.
      opnum_to_ex <= '0;
    end else begin
      q1_busy_reg <= q1_busy_next;
      q2_busy_reg <= q2_busy_next;
      for (int i = 0; i < DEPTH; i++) begin
        v1_reg[i] <= v1_next[i];
        v2_reg[i] <= v2_next[i];
      end
      if (issue_fire) begin
        busy_reg[sel_idx] <= 1'b0;
        opnum_to_ex       <= opnum_reg[sel_idx];
        V1_to_ex          <= v1_reg[sel_idx];
        V2_to_ex          <= v2_reg[sel_idx];
        imm_to_ex         <= imm_reg[sel_idx];
        pc_to_ex          <= pc_reg[sel_idx];
        rob_id_to_ex      <= rob_id_reg[sel_idx];
      end else begin
        opnum_to_ex <= '0;
      end
      // A free slot is never a select candidate, so these writes cannot collide.
      if (alloc_fire) begin
        busy_reg[free_idx]    <= 1'b1;
        opnum_reg[free_idx]   <= alloc_opnum;
        v1_reg[free_idx]      <= alloc_v1;
        v2_reg[free_idx]      <= alloc_v2;
        q1_busy_reg[free_idx] <= alloc_q1_busy;
        q2_busy_reg[free_idx] <= alloc_q2_busy;
        q1_reg[free_idx]      <= alloc_Q1;
        q2_reg[free_idx]      <= alloc_Q2;
        imm_reg[free_idx]     <= alloc_imm;
        pc_reg[free_idx]      <= alloc_pc;
        rob_id_reg[free_idx]  <= alloc_rob_id;
      end
      count_reg <= count_next;
    end
  end

endmodule
